ext_irq_ctrl: RTL and testbench

EXT_IRQ_CTRL -- requirements
Module: ext_irq_ctrl

---
 rtl/ext_irq_pkg.sv | 20 ++
 rtl/ext_irq_ctrl_prio_enc.sv | 22 ++
 rtl/ext_irq_ctrl.sv | 141 ++++++++++++++
 tb/tb_ext_irq_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ext_irq_pkg.sv
// Shared constants and types for the external interrupt controller.
package ext_irq_pkg;

  localparam int unsigned NUM_SRC_DEF = 16;
  // Wide enough for in-service id+1 with up to 31 sources
  localparam int unsigned ID_W        = 5;

  localparam logic [4:0] OFF_PENDING  = 5'h00;
  localparam logic [4:0] OFF_ENABLE   = 5'h04;
  localparam logic [4:0] OFF_TRIGGER  = 5'h08;
  localparam logic [4:0] OFF_CLAIM    = 5'h0C;
  localparam logic [4:0] OFF_COMPLETE = 5'h10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    SERVE = 2'd2
  } irq_state_e;

endpackage

// File: rtl/ext_irq_ctrl_prio_enc.sv
// Lowest-index-first priority encoder: index 0 wins.
module irq_prio_enc #(
  parameter int unsigned N     = 16,
  parameter int unsigned IDX_W = 5
) (
  input  logic [N-1:0]     req,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req[i] && !valid) begin
        valid = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/ext_irq_ctrl.sv
// External interrupt controller: pending/enable/trigger registers, claim/complete FSM.
// Optional macro EXT_IRQ_SYNC_EN adds a two-flop synchronizer ahead of edge detection.
module ext_irq_ctrl
  import ext_irq_pkg::*;
#(
  parameter int unsigned NUM_SRC = NUM_SRC_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               sel,
  input  logic               we,
  input  logic [4:0]         addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  input  logic               irq_ack,
  output logic               meip
);

  logic [NUM_SRC-1:0] sync_out;

`ifdef EXT_IRQ_SYNC_EN
  logic [NUM_SRC-1:0] sync1, sync2;
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= irq_src;
      sync2 <= sync1;
    end
  end
  assign sync_out = sync2;
`else
  logic [NUM_SRC-1:0] in_q;
  always_ff @(posedge clk) begin
    if (reset) in_q <= '0;
    else       in_q <= irq_src;
  end
  assign sync_out = in_q;
`endif

  logic [NUM_SRC-1:0] lvl_q, lvl_d, rise;
  logic [NUM_SRC-1:0] pending, pending_nxt, enable, trigger;
  logic [ID_W-1:0]    svc_id, cand_idx;
  logic               cand_valid;
  irq_state_e         state, state_nxt;
  logic [31:0]        rd_val;
  logic               wr_en, rd_en, complete_hit, claim;
  logic [NUM_SRC-1:0] w1c_mask;
  logic               unused_wdata;

  assign unused_wdata = ^wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      lvl_q <= '0;
      lvl_d <= '0;
    end else begin
      lvl_q <= sync_out;
      lvl_d <= lvl_q;
    end
  end

  assign rise = lvl_q & ~lvl_d;

  irq_prio_enc #(
    .N     (NUM_SRC),
    .IDX_W (ID_W)
  ) u_prio (
    .req   (pending & enable),
    .valid (cand_valid),
    .idx   (cand_idx)
  );

  assign wr_en        = sel & we;
  assign rd_en        = sel & ~we;
  assign w1c_mask     = (wr_en && addr == OFF_PENDING) ? wdata[NUM_SRC-1:0] : '0;
  assign claim        = (state == REQ) && irq_ack && cand_valid;
  assign complete_hit = wr_en && (addr == OFF_COMPLETE) && (state == SERVE) &&
                        (wdata[ID_W-1:0] == svc_id + ID_W'(1));

  // Edge bits: set beats clear. Level bits track the line but read 0 while in service,
  // so a level dropped during service does not re-request after COMPLETE.
  always_comb begin
    pending_nxt = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (trigger[i]) begin
        pending_nxt[i] = rise[i] |
                         (pending[i] & ~(w1c_mask[i] | (claim && cand_idx == ID_W'(i))));
      end else begin
        pending_nxt[i] = lvl_q[i] & ~((state == SERVE) && (svc_id == ID_W'(i)));
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cand_valid) state_nxt = REQ;
      REQ: begin
        if (!cand_valid)  state_nxt = IDLE;
        else if (irq_ack) state_nxt = SERVE;
      end
      SERVE:   if (complete_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_val = '0;
    case (addr)
      OFF_PENDING: rd_val[NUM_SRC-1:0] = pending;
      OFF_ENABLE:  rd_val[NUM_SRC-1:0] = enable;
      OFF_TRIGGER: rd_val[NUM_SRC-1:0] = trigger;
      OFF_CLAIM:   if (state == SERVE) rd_val[ID_W-1:0] = svc_id + ID_W'(1);
      default:     rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pending <= '0;
      enable  <= '0;
      trigger <= '0;
      svc_id  <= '0;
      rdata   <= '0;
      meip    <= 1'b0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      meip    <= (state_nxt == REQ);
      if (claim) svc_id <= cand_idx;
      if (wr_en && addr == OFF_ENABLE)  enable  <= wdata[NUM_SRC-1:0];
      if (wr_en && addr == OFF_TRIGGER) trigger <= wdata[NUM_SRC-1:0];
      if (rd_en) rdata <= rd_val;
    end
  end

endmodule

// File: tb/tb_ext_irq_ctrl.sv
// Directed self-checking bench for ext_irq_ctrl: register table plus claim/complete sequences.
module tb_ext_irq_ctrl;
  import ext_irq_pkg::*;

  localparam int unsigned NS = 16;
`ifdef EXT_IRQ_SYNC_EN
  localparam int PLAT = 3;
`else
  localparam int PLAT = 2;
`endif
  localparam int MLAT = PLAT + 1;

  logic          clk = 1'b0;
  logic          reset, sel, we, irq_ack, meip;
  logic [4:0]    addr;
  logic [31:0]   wdata, rdata;
  logic [NS-1:0] irq_src;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ext_irq_ctrl #(.NUM_SRC(NS)) dut (
    .clk     (clk),
    .reset   (reset),
    .irq_src (irq_src),
    .sel     (sel),
    .we      (we),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .irq_ack (irq_ack),
    .meip    (meip)
  );

  typedef struct {
    logic        do_wr;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    cyc();
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
    sel = 1'b1; we = 1'b0; addr = a;
    cyc();
    sel = 1'b0;
    check(name, rdata, exp);
  endtask

  task automatic ack();
    irq_ack = 1'b1;
    cyc();
    irq_ack = 1'b0;
  endtask

  task automatic wait_meip(input string name, input int budget);
    int n = 0;
    while (meip !== 1'b1 && n < budget) begin
      cyc();
      n++;
    end
    check(name, {31'b0, meip}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic seen;

    vecs[0]  = '{1'b0, 5'h00,       32'h0,        OFF_ENABLE,  32'h0};
    vecs[1]  = '{1'b0, 5'h00,       32'h0,        OFF_TRIGGER, 32'h0};
    vecs[2]  = '{1'b0, 5'h00,       32'h0,        OFF_PENDING, 32'h0};
    vecs[3]  = '{1'b0, 5'h00,       32'h0,        OFF_CLAIM,   32'h0};
    vecs[4]  = '{1'b1, OFF_ENABLE,  32'hFFFF_FFFF, OFF_ENABLE, 32'h0000_FFFF};
    vecs[5]  = '{1'b1, 5'h14,       32'hDEAD_BEEF, OFF_ENABLE, 32'h0000_FFFF};
    vecs[6]  = '{1'b1, 5'h14,       32'hDEAD_BEEF, 5'h14,      32'h0};
    vecs[7]  = '{1'b1, OFF_TRIGGER, 32'h0001_A5A5, OFF_TRIGGER, 32'h0000_A5A5};
    vecs[8]  = '{1'b1, OFF_COMPLETE, 32'h1,       OFF_COMPLETE, 32'h0};
    vecs[9]  = '{1'b0, 5'h00,       32'h0,        5'h05,       32'h0};
    vecs[10] = '{1'b1, OFF_ENABLE,  32'h0000_1234, OFF_ENABLE, 32'h0000_1234};
    vecs[11] = '{1'b1, OFF_PENDING, 32'h0000_FFFF, OFF_PENDING, 32'h0};
    vecs[12] = '{1'b1, OFF_ENABLE,  32'h0,        OFF_ENABLE,  32'h0};
    vecs[13] = '{1'b1, OFF_TRIGGER, 32'h0,        5'h1C,       32'h0};

    reset = 1'b1; sel = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    irq_src = '0; irq_ack = 1'b0;
    repeat (3) cyc();
    reset = 1'b0;
    check("reset_rdata", rdata, 32'h0);
    check("reset_meip", {31'b0, meip}, 32'h0);

    for (int unsigned i = 0; i < 14; i++) begin
      if (vecs[i].do_wr) wr(vecs[i].waddr, vecs[i].wdata);
      rd_chk($sformatf("vec%0d", i), vecs[i].raddr, vecs[i].exp);
    end

    // rdata must hold across idle cycles and writes
    wr(OFF_ENABLE, 32'h5A);
    rd_chk("hold_setup", OFF_ENABLE, 32'h5A);
    repeat (3) cyc();
    check("hold_idle", rdata, 32'h5A);
    wr(OFF_ENABLE, 32'h0);
    check("hold_write", rdata, 32'h5A);

    // Single edge pulse on source 0
    wr(OFF_ENABLE, 32'h1);
    wr(OFF_TRIGGER, 32'h1);
    irq_src[0] = 1'b1;
    cyc();
    irq_src[0] = 1'b0;
    repeat (MLAT - 1) cyc();
    check("s0_meip_early", {31'b0, meip}, 32'h0);
    cyc();
    check("s0_meip_rise", {31'b0, meip}, 32'h1);
    ack();
    check("s0_meip_after_ack", {31'b0, meip}, 32'h0);
    rd_chk("s0_claim", OFF_CLAIM, 32'h1);
    rd_chk("s0_pending", OFF_PENDING, 32'h0);
    ack();
    rd_chk("s0_ack_in_serve", OFF_CLAIM, 32'h1);
    wr(OFF_COMPLETE, 32'h1);
    rd_chk("s0_claim_done", OFF_CLAIM, 32'h0);
    ack();
    rd_chk("ack_in_idle", OFF_CLAIM, 32'h0);
    check("ack_in_idle_meip", {31'b0, meip}, 32'h0);

    // Sources 1 and 2 together: lower index first
    wr(OFF_ENABLE, 32'h6);
    wr(OFF_TRIGGER, 32'h6);
    irq_src[2:1] = 2'b11;
    cyc();
    irq_src[2:1] = 2'b00;
    wait_meip("s12_meip1", MLAT + 4);
    ack();
    rd_chk("s12_claim1", OFF_CLAIM, 32'h2);
    rd_chk("s12_pending", OFF_PENDING, 32'h4);
    wr(OFF_COMPLETE, 32'h2);
    wait_meip("s12_meip2", 6);
    ack();
    rd_chk("s12_claim2", OFF_CLAIM, 32'h3);
    wr(OFF_COMPLETE, 32'h5);
    rd_chk("bad_complete", OFF_CLAIM, 32'h3);
    check("bad_complete_meip", {31'b0, meip}, 32'h0);
    wr(OFF_ENABLE, 32'h0);
    rd_chk("disable_in_serve", OFF_CLAIM, 32'h3);
    wr(OFF_COMPLETE, 32'h3);
    rd_chk("good_complete", OFF_CLAIM, 32'h0);
    rd_chk("s12_pending_end", OFF_PENDING, 32'h0);

    // Level source 4 held through COMPLETE re-requests
    wr(OFF_TRIGGER, 32'h0);
    wr(OFF_ENABLE, 32'h10);
    irq_src[4] = 1'b1;
    wait_meip("lvl_meip1", MLAT + 4);
    ack();
    rd_chk("lvl_claim1", OFF_CLAIM, 32'h5);
    wr(OFF_COMPLETE, 32'h5);
    seen = 1'b0;
    for (int unsigned k = 0; k < 2; k++) begin
      cyc();
      if (meip === 1'b1) seen = 1'b1;
    end
    check("lvl_rereq", {31'b0, seen}, 32'h1);
    ack();
    rd_chk("lvl_claim2", OFF_CLAIM, 32'h5);
    irq_src[4] = 1'b0;
    repeat (PLAT + 2) cyc();
    wr(OFF_COMPLETE, 32'h5);
    seen = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      cyc();
      if (meip !== 1'b0) seen = 1'b1;
    end
    check("lvl_dropped_no_req", {31'b0, seen}, 32'h0);
    rd_chk("lvl_claim_end", OFF_CLAIM, 32'h0);

    // Candidate vanishing in REQ drops meip without a claim
    irq_src[4] = 1'b1;
    wait_meip("vanish_meip", MLAT + 4);
    irq_src[4] = 1'b0;
    seen = 1'b1;
    for (int unsigned k = 0; k < 10 && seen; k++) begin
      cyc();
      if (meip === 1'b0) seen = 1'b0;
    end
    check("vanish_meip_drop", {31'b0, meip}, 32'h0);
    rd_chk("vanish_claim", OFF_CLAIM, 32'h0);

    // W1C of PENDING[0], alone and coinciding with a new edge
    wr(OFF_ENABLE, 32'h0);
    wr(OFF_TRIGGER, 32'h1);
    irq_src[0] = 1'b1;
    cyc();
    irq_src[0] = 1'b0;
    repeat (PLAT + 2) cyc();
    rd_chk("w1c_setup", OFF_PENDING, 32'h1);
    wr(OFF_PENDING, 32'h1);
    rd_chk("w1c_clear", OFF_PENDING, 32'h0);
    irq_src[0] = 1'b1;
    cyc();
    irq_src[0] = 1'b0;
    repeat (PLAT - 1) cyc();
    wr(OFF_PENDING, 32'h1);
    rd_chk("w1c_vs_edge", OFF_PENDING, 32'h1);
    wr(OFF_PENDING, 32'h1);
    rd_chk("w1c_after", OFF_PENDING, 32'h0);

    // Reset during SERVE
    wr(OFF_TRIGGER, 32'h0);
    wr(OFF_ENABLE, 32'h10);
    irq_src[4] = 1'b1;
    wait_meip("rst_meip", MLAT + 4);
    ack();
    rd_chk("rst_claim_before", OFF_CLAIM, 32'h5);
    irq_src = '0;
    reset = 1'b1;
    cyc();
    check("rst_meip", {31'b0, meip}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    reset = 1'b0;
    rd_chk("rst_claim", OFF_CLAIM, 32'h0);
    rd_chk("rst_enable", OFF_ENABLE, 32'h0);
    rd_chk("rst_pending", OFF_PENDING, 32'h0);
    rd_chk("rst_trigger", OFF_TRIGGER, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
